// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command/response FIFO controller.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        WAITV = 3'd2,
        SHIFT = 3'd3,
        RESP  = 3'd4,
        GAP   = 3'd5
    } spi_state_t;

    localparam int SPI_CLK_DIV_DEFAULT = 4;

    // Command word layout: {rw, addr[WIDTH-1:0], wdata[WIDTH-1:0]}.
    localparam int CMD_WDATA_LSB = 0;

    function automatic int cmd_rw_bit(input int width);
        return 2 * width;
    endfunction

    function automatic int cmd_addr_lsb(input int width);
        return width;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period generator: idles low while stopped, toggles every CLK_DIV
// PCLK cycles while running, and flags the cycle before each edge.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_r;
    logic       sclk_r;
    logic       tick_s;

    assign tick_s = run && (cnt_r == HALF_LAST);
    assign rise   = tick_s && !sclk_r;
    assign fall   = tick_s && sclk_r;
    assign sclk   = sclk_r;

    // Half-period counter and SCLK level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= 8'd0;
            sclk_r <= 1'b0;
        end else if (!run) begin
            cnt_r  <= 8'd0;
            sclk_r <= 1'b0;
        end else if (tick_s) begin
            cnt_r  <= 8'd0;
            sclk_r <= ~sclk_r;
        end else begin
            cnt_r  <= cnt_r + 8'd1;
            sclk_r <= sclk_r;
        end
    end

endmodule

// File: rtl/spi_fifo_ctrl.sv
// SPI mode-0 master: pops command words from a FIFO, shifts each as one
// 2*WIDTH-bit frame and pushes the read byte into a response FIFO.
module spi_fifo_ctrl
    import spi_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               enable,
    input  logic               cmd_empty,
    input  logic               cmd_rst_busy,
    output logic               cmd_rd_en,
    input  logic               cmd_valid,
    input  logic [2*WIDTH:0]   cmd_dout,
    input  logic               rsp_full,
    output logic               rsp_wr_en,
    output logic [WIDTH-1:0]   rsp_din,
    output logic               sclk,
    output logic               cs_n,
    output logic               mosi,
    input  logic               miso,
    output logic               busy
);

    localparam int FRAME_W  = 2 * WIDTH;
    localparam int RW_BIT   = cmd_rw_bit(WIDTH);
    localparam int ADDR_MSB = cmd_addr_lsb(WIDTH) + WIDTH - 1;
    localparam int BIT_W    = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] LAST_FALL = BIT_W'(FRAME_W - 1);
    localparam logic [7:0]       GAP_LAST  = 8'(CLK_DIV - 1);

    spi_state_t         state_r, state_s;
    logic [2*WIDTH:0]   tx_r, tx_s;
    logic [WIDTH-1:0]   rx_r, rx_s;
    logic [WIDTH-1:0]   din_r, din_s;
    logic [BIT_W-1:0]   fall_cnt_r, fall_cnt_s;
    logic [7:0]         gap_cnt_r, gap_cnt_s;
    logic               rw_r, rw_s;
    logic               cs_n_r, cs_n_s;
    logic               mosi_r, mosi_s;
    logic               rd_en_r, rd_en_s;
    logic               wr_en_r, wr_en_s;
    logic               busy_r, busy_s;
    logic               run_s, sclk_s, rise_s, fall_s;

    assign run_s = (state_r == SHIFT);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk  (PCLK),
        .rst  (PRESET),
        .run  (run_s),
        .sclk (sclk_s),
        .rise (rise_s),
        .fall (fall_s)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        tx_s       = tx_r;
        rx_s       = rx_r;
        din_s      = din_r;
        fall_cnt_s = fall_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        rw_s       = rw_r;
        cs_n_s     = cs_n_r;
        mosi_s     = mosi_r;
        rd_en_s    = 1'b0;
        wr_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable && !cmd_empty && !cmd_rst_busy) begin
                    state_s = POP;
                    rd_en_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            POP: begin
                state_s = WAITV;
            end
            WAITV: begin
                if (cmd_rst_busy) begin
                    state_s = IDLE;
                end else if (cmd_valid) begin
                    state_s    = SHIFT;
                    tx_s       = cmd_dout;
                    rw_s       = cmd_dout[RW_BIT];
                    mosi_s     = cmd_dout[RW_BIT];
                    cs_n_s     = 1'b0;
                    fall_cnt_s = '0;
                    rx_s       = '0;
                end else begin
                    state_s = WAITV;
                end
            end
            SHIFT: begin
                if (rise_s) begin
                    rx_s = WIDTH'({rx_r, miso});
                end else begin
                    rx_s = rx_r;
                end
                if (fall_s && (fall_cnt_r == LAST_FALL)) begin
                    state_s   = rw_r ? RESP : GAP;
                    cs_n_s    = 1'b1;
                    mosi_s    = 1'b0;
                    gap_cnt_s = 8'd0;
                end else if (fall_s && (fall_cnt_r == '0)) begin
                    // The address MSB is not transmitted: skip it after rw.
                    fall_cnt_s = fall_cnt_r + BIT_W'(1);
                    tx_s       = {tx_r[ADDR_MSB-1:0], 2'b00};
                    mosi_s     = tx_r[ADDR_MSB-1];
                end else if (fall_s) begin
                    fall_cnt_s = fall_cnt_r + BIT_W'(1);
                    tx_s       = {tx_r[RW_BIT-1:0], 1'b0};
                    mosi_s     = tx_r[RW_BIT-1];
                end else begin
                    state_s = SHIFT;
                end
            end
            RESP: begin
                if (rsp_full) begin
                    state_s = RESP;
                end else begin
                    state_s   = GAP;
                    wr_en_s   = 1'b1;
                    din_s     = rx_r;
                    gap_cnt_s = 8'd0;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cs_n_s  = 1'b1;
                mosi_s  = 1'b0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // FSM state register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_r       <= '0;
            rx_r       <= '0;
            din_r      <= '0;
            fall_cnt_r <= '0;
            gap_cnt_r  <= 8'd0;
            rw_r       <= 1'b0;
            cs_n_r     <= 1'b1;
            mosi_r     <= 1'b0;
            rd_en_r    <= 1'b0;
            wr_en_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            tx_r       <= tx_s;
            rx_r       <= rx_s;
            din_r      <= din_s;
            fall_cnt_r <= fall_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            rw_r       <= rw_s;
            cs_n_r     <= cs_n_s;
            mosi_r     <= mosi_s;
            rd_en_r    <= rd_en_s;
            wr_en_r    <= wr_en_s;
            busy_r     <= busy_s;
        end
    end

    assign cmd_rd_en = rd_en_r;
    assign rsp_wr_en = wr_en_r;
    assign rsp_din   = din_r;
    assign sclk      = sclk_s;
    assign cs_n      = cs_n_r;
    assign mosi      = mosi_r;
    assign busy      = busy_r;

endmodule
